scalar_sel_arb: RTL and testbench

SCALAR_SEL_ARB -- requirements
Module: scalar_sel_arb

---
 rtl/scalar_sel_arb_pkg.sv | 19 +
 rtl/scalar_sel_arb_rr_pick.sv | 35 +++
 rtl/scalar_sel_arb.sv | 98 +++++++++
 tb/tb_scalar_sel_arb.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/scalar_sel_arb_pkg.sv
// Shared definitions for the scalar select/arbiter: mode encodings, default sizes,
// and the modular wrap helper used by the round-robin search.
package scalar_sel_arb_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  localparam int DEF_N  = 32;
  localparam int DEF_CH = 8;
  localparam int DEF_SW = 4;

  // Fold an index in [0, 2*ch) back into [0, ch).
  function automatic int wrap_idx(input int v, input int ch);
    return (v >= ch) ? (v - ch) : v;
  endfunction

endpackage

// File: rtl/scalar_sel_arb_rr_pick.sv
// Round-robin priority search: first valid channel after ptr, wrapping CH-1 -> 0.
// Purely combinational; no backpressure of its own.
module rr_pick
  import scalar_sel_arb_pkg::*;
#(
  parameter int CH = DEF_CH,
  parameter int SW = DEF_SW
) (
  input  logic [CH-1:0] in_valid,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] grant,
  output logic          found
);

  localparam int IW = $clog2(CH);

  logic [2*CH-1:0] dbl;
  logic [CH-1:0]   rot;

  // Bit j of rot is channel (ptr+1+j) mod CH; shifting the doubled vector does the wrap.
  assign dbl = {in_valid, in_valid};
  assign rot = CH'(dbl >> (ptr + SW'(1)));

  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int j = 0; j < CH; j++) begin
      if (!found && rot[j[IW-1:0]]) begin
        found = 1'b1;
        grant = SW'(wrap_idx(int'(ptr) + 1 + j, CH));
      end
    end
  end

endmodule

// File: rtl/scalar_sel_arb.sv
// Channel selector/arbiter: direct select or round-robin into one output register.
// Latency 1 cycle grant->out_valid; grants only when the register is empty or draining.
module scalar_sel_arb
  import scalar_sel_arb_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int CH = DEF_CH,
  parameter int SW = DEF_SW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [CH-1:0]   in_valid,
  input  logic [CH*N-1:0] in_data,
  output logic [CH-1:0]   in_ready,
  output logic            out_valid,
  output logic [N-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  input  logic            out_ready,
  input  logic            err_clr,
  output logic            sel_err
);

  localparam int IW = $clog2(CH);

  logic [N-1:0]  ch_dat [CH];
  logic [SW-1:0] ptr;
  logic [SW-1:0] rr_idx;
  logic          rr_found;
  logic          mode_rr;
  logic          can_load;
  logic          sel_bad;
  logic          dir_hit;
  logic [SW-1:0] gnt_idx;
  logic          gnt_vld;
  logic [N-1:0]  gnt_dat;

  for (genvar g = 0; g < CH; g++) begin : g_unpack
    assign ch_dat[g] = in_data[g*N +: N];
  end

  assign mode_rr  = (mode_e'(mode) == MODE_RR);
  assign can_load = !out_valid || out_ready;
  assign sel_bad  = (int'(sel) >= CH);

  rr_pick #(
    .CH (CH),
    .SW (SW)
  ) u_rr_pick (
    .in_valid (in_valid),
    .ptr      (ptr),
    .grant    (rr_idx),
    .found    (rr_found)
  );

  assign gnt_idx = mode_rr ? rr_idx : sel;

  // Index-compare muxes: an out-of-range index matches nothing and yields zero.
  always_comb begin
    dir_hit = 1'b0;
    gnt_dat = '0;
    for (int k = 0; k < CH; k++) begin
      if (sel == SW'(k))
        dir_hit = in_valid[k[IW-1:0]];
      if (gnt_idx == SW'(k))
        gnt_dat = ch_dat[k[IW-1:0]];
    end
  end

  assign gnt_vld  = rst_n && can_load && (mode_rr ? rr_found : (dir_hit && !sel_bad));
  assign in_ready = gnt_vld ? (CH'(1) << gnt_idx) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      sel_err   <= 1'b0;
      ptr       <= SW'(CH - 1);
    end else begin
      // Empty register reads as zero so idle cycles never expose stale data.
      if (can_load) begin
        out_valid <= gnt_vld;
        out_data  <= gnt_vld ? gnt_dat : '0;
        out_ch    <= gnt_vld ? gnt_idx : '0;
      end
      // Only round-robin grants move the pointer, so direct traffic leaves the rotation intact.
      if (gnt_vld && mode_rr)
        ptr <= rr_idx;
      if (err_clr)
        sel_err <= 1'b0;
      else if (!mode_rr && sel_bad && (|in_valid))
        sel_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scalar_sel_arb.sv
// Directed bench for scalar_sel_arb (CH=8, N=32): reset, direct, error flag,
// round-robin fairness, backpressure and mode switching.
module tb_scalar_sel_arb;

  localparam int N  = 32;
  localparam int CH = 8;
  localparam int SW = 4;

  logic            clk;
  logic            rst_n;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [CH-1:0]   in_valid;
  logic [CH*N-1:0] in_data;
  logic [CH-1:0]   in_ready;
  logic            out_valid;
  logic [N-1:0]    out_data;
  logic [SW-1:0]   out_ch;
  logic            out_ready;
  logic            err_clr;
  logic            sel_err;

  int vectors;
  int miscompares;

  scalar_sel_arb #(.N(N), .CH(CH), .SW(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .sel_err   (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = '0;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    for (int k = 0; k < CH; k++)
      in_data[k*N +: N] = 32'hDEAD0000 + 32'(k);

    // Reset: no grants while held, register cleared
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_ch", 64'(out_ch), 64'h0);
    chk("rst_sel_err", 64'(sel_err), 64'h0);

    // Direct load of ch3
    rst_n    = 1'b1;
    mode     = 1'b0;
    sel      = 4'd3;
    in_valid = 8'h08;
    @(negedge clk);
    chk("dir_in_ready", 64'(in_ready), 64'h08);
    tick();
    chk("dir_out_valid", 64'(out_valid), 64'h1);
    chk("dir_out_data", 64'(out_data), 64'hDEAD0003);
    chk("dir_out_ch", 64'(out_ch), 64'h3);
    in_valid = 8'h00;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'h0);
    tick();
    chk("drain_out_valid", 64'(out_valid), 64'h0);
    chk("drain_out_data", 64'(out_data), 64'h0);

    // Out-of-range select, then clear winning over a simultaneous set
    sel      = 4'hA;
    in_valid = 8'hFF;
    @(negedge clk);
    chk("oor_in_ready", 64'(in_ready), 64'h0);
    tick();
    chk("oor_out_valid", 64'(out_valid), 64'h0);
    chk("oor_sel_err_set", 64'(sel_err), 64'h1);
    err_clr = 1'b1;
    tick();
    chk("oor_clr_wins", 64'(sel_err), 64'h0);
    err_clr  = 1'b0;
    in_valid = 8'h00;
    tick();
    chk("oor_stays_clear", 64'(sel_err), 64'h0);

    // Round-robin fairness from reset
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    mode      = 1'b1;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rr_in_ready", 64'(in_ready), 64'h1 << (i % 8));
      tick();
      chk("rr_out_ch", 64'(out_ch), 64'(i % 8));
      chk("rr_out_valid", 64'(out_valid), 64'h1);
    end

    // Backpressure with ch0 and ch5 requesting
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    in_valid  = 8'h21;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_first_grant", 64'(in_ready), 64'h01);
    tick();
    chk("bp_first_ch", 64'(out_ch), 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_stall_in_ready", 64'(in_ready), 64'h0);
      tick();
      chk("bp_hold_ch", 64'(out_ch), 64'h0);
      chk("bp_hold_data", 64'(out_data), 64'hDEAD0000);
      chk("bp_hold_valid", 64'(out_valid), 64'h1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 64'(in_ready), 64'h20);
    tick();
    chk("bp_next_ch5", 64'(out_ch), 64'h5);
    chk("bp_next_data5", 64'(out_data), 64'hDEAD0005);
    @(negedge clk);
    chk("bp_wrap_in_ready", 64'(in_ready), 64'h01);
    tick();
    chk("bp_next_ch0", 64'(out_ch), 64'h0);

    // Reset while a word is held and stalled discards it
    out_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst_mid_valid", 64'(out_valid), 64'h0);
    chk("rst_mid_data", 64'(out_data), 64'h0);

    // Mode switch: RR grants ch2, direct takes ch6, RR resumes at ch3
    rst_n     = 1'b1;
    mode      = 1'b1;
    in_valid  = 8'h04;
    out_ready = 1'b1;
    tick();
    chk("ms_rr_ch2", 64'(out_ch), 64'h2);
    mode     = 1'b0;
    sel      = 4'd6;
    in_valid = 8'h40;
    @(negedge clk);
    chk("ms_dir_in_ready", 64'(in_ready), 64'h40);
    tick();
    chk("ms_dir_ch6", 64'(out_ch), 64'h6);
    chk("ms_dir_valid", 64'(out_valid), 64'h1);
    mode     = 1'b1;
    sel      = 4'hF;
    in_valid = 8'hFF;
    @(negedge clk);
    chk("ms_rr_in_ready", 64'(in_ready), 64'h08);
    tick();
    chk("ms_rr_resume_ch3", 64'(out_ch), 64'h3);
    chk("ms_rr_no_sel_err", 64'(sel_err), 64'h0);
    tick();
    chk("ms_rr_ch4", 64'(out_ch), 64'h4);
    in_valid = 8'h00;
    tick();
    chk("ms_end_valid", 64'(out_valid), 64'h0);
    chk("ms_end_ch", 64'(out_ch), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
